alu4_nibble_sequencer: RTL
==========================

# alu4_nibble_sequencer

Multi-precision controller for the 4-bit ALU slice. It takes one wide operation (`4*NIBBLES` bits) and runs it through the external ALU one nibble per cycle. Between passes it carries the math carry and the rotate carry forward. It collects the result and flags, and reports completion with a start/busy/done handshake. It sits between the command source (pins or a host FSM) and the combinational ALU, and is the ALU's only driver.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles. Legal range is 2–8. Width `W = 4*NIBBLES`.

Ports:
- `clk`  in  1  the only clock; every flop is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command request; sampled only in IDLE.
- `cmd_op_first`  in  4  ALU opcode for the first nibble pass.
- `cmd_op_chain`  in  4  ALU opcode for every later pass (the carry-in-from-pin variant).
- `cmd_msb_first`  in  1  0 = LSB-first (add/sub/shift-left); 1 = MSB-first (shift/rotate-right).
- `cmd_a`, `cmd_b`  in  W  operands.
- `cmd_mci`, `cmd_rci`  in  1  initial math / rotate carry.
- `alu_op`  out  4  opcode to the ALU.
- `alu_a`, `alu_b`  out  4  nibble operands to the ALU.
- `alu_mci`, `alu_rci`  out  1  carries to the ALU.
- `alu_out`  in  4  ALU result nibble.
- `alu_mco`, `alu_rco`, `alu_ovf`  in  1  ALU carry and overflow outputs.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  W  assembled result; held until the next accepted start.
- `mco`, `rco`, `ovf`, `zero`  out  1  final flags; held like `result`.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- In IDLE with `start`=1, the block captures all `cmd_*` into registers.
  - `idx` is set to 0 for LSB-first or `NIBBLES-1` for MSB-first.
  - `pass` is cleared to 0 and the zero accumulator is set to 1.
  - The state moves to RUN.
- RUN drives the ALU combinationally from the registers:
  - `alu_op` = `op_first` when `pass`==0, otherwise `op_chain`.
  - `alu_a`/`alu_b` = nibble `idx` of the captured A/B.
  - On `pass`==0, `alu_mci`/`alu_rci` are the captured `cmd_mci`/`cmd_rci`. On later passes they are the registered `alu_mco`/`alu_rco` from the previous pass.
- At each RUN edge:
  - `alu_out` is written into nibble `idx` of the result register.
  - The carry registers take `alu_mco`/`alu_rco`.
  - `zacc &= (alu_out==0)`.
  - `ovf_r` takes `alu_ovf`.
  - `idx` steps by ±1 and `pass` increments.
- After the pass with `pass`==`NIBBLES-1`, the state moves to DONE.
  - The flag outputs load the last carries, the last `alu_ovf`, and `zacc`.
  - `result` is updated from the working register.
- DONE lasts one cycle with `done`=1, then the state returns to IDLE.
- Outside RUN, `alu_op`/`alu_a`/`alu_b`/`alu_mci`/`alu_rci` are driven to 0.
- `start` is ignored in RUN and in DONE. There is no queueing.
- `result` and the flags change only on entry to DONE. A command in flight never disturbs the previously held result.
- Reset from any state, including mid-RUN:
  - Goes to IDLE and aborts the command.
  - Clears `busy`, `done`, `result`, `mco`, `rco`, `ovf`, `zero`, `idx`, `pass`, and all captured registers to 0.
  - Partial results are discarded.

## Timing
- Edge E0 samples `start`. `busy`=1 from E0 until E(N+1).
- Passes are captured on edges E1..EN, with `N=NIBBLES`.
- `done`=1 in the cycle after EN. `result` and the flags are valid from that cycle on.
- Start-to-done latency is N+1 cycles. Back-to-back throughput is one command per N+2 cycles: the earliest next `start` is sampled in IDLE at E(N+2).
- The ALU path is a single combinational cycle: from the register outputs, through the ALU, into the result and carry flops.
- Every output is registered except the `alu_*` drives, which are decoded from registered state only.

## Structure
- Package `alu4_seq_pkg` holds:
  - the state enum `seq_state_t` {IDLE, RUN, DONE};
  - the default `NIBBLES`;
  - the function `nib_sel(vec, idx)`.
- The block instantiates no sub-modules. The ALU stays external so the same sequencer can drive the ALU model in simulation or the real slice.
- A natural optional sub-module is `nibble_bank`: W-bit registers with per-index nibble write and read.

## Test plan
Benches use a behavioural ALU model that is combinational and matches the slice's carry and zero semantics.
- **LSB-first add:** ADD/ADD-with-carry, A=0x00FF, B=0x0001, mci=0 → `done` on cycle 5; `result`=0x0100, `mco`=0, `zero`=0.
- **Carry-out and zero:** ADD, A=0xFFFF, B=0x0001 → `result`=0x0000, `mco`=1, `zero`=1.
- **MSB-first rotate-right:** rotate-right-through-carry, A=0x8001, rci=1 → `result`=0xC000, `rco`=1. Check that `alu_a` goes 0x8,0x0,0x0,0x1 on passes 0–3.
- **Start while busy:** a second `start` at E2 is ignored. Exactly one `done` appears, and `result` matches the first command only.
- **Reset mid-RUN:** `rst`=1 at E2 → next cycle `busy`=0, `result`=0, and no `done`. A fresh command afterwards completes normally.
- **Back-to-back and hold:** `start` held high continuously → `done` pulses every 6 cycles. `result` stays stable between pulses even though the inputs change.

Source files
------------

// File: rtl/alu4_seq_pkg.sv
// Shared types and helpers for the nibble sequencer.
// State encoding, default width, nibble select.
package alu4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int NIBBLES_DEF = 4;

  // Pick nibble idx out of a vector zero-extended to 32 bits.
  function automatic logic [3:0] nib_sel(
    input logic [31:0] vec,
    input logic [2:0]  idx
  );
    return vec[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/alu4_nibble_sequencer.sv
// Runs one wide operation through an external 4-bit ALU,
// one nibble per cycle, with carry chaining and flag collection.
module alu4_nibble_sequencer
  import alu4_seq_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           cmd_op_first,
  input  logic [3:0]           cmd_op_chain,
  input  logic                 cmd_msb_first,
  input  logic [4*NIBBLES-1:0] cmd_a,
  input  logic [4*NIBBLES-1:0] cmd_b,
  input  logic                 cmd_mci,
  input  logic                 cmd_rci,
  output logic [3:0]           alu_op,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_mci,
  output logic                 alu_rci,
  input  logic [3:0]           alu_out,
  input  logic                 alu_mco,
  input  logic                 alu_rco,
  input  logic                 alu_ovf,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 mco,
  output logic                 rco,
  output logic                 ovf,
  output logic                 zero
);

  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  seq_state_t r_state;
  seq_state_t w_state_nx;

  logic         r_busy;
  logic         r_done;
  logic [3:0]   r_op_first;
  logic [3:0]   r_op_chain;
  logic         r_msb;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_mc;
  logic         r_rc;
  logic         r_zacc;
  logic [2:0]   r_idx;
  logic [2:0]   r_pass;
  logic [W-1:0] r_work;
  logic [W-1:0] r_result;
  logic         r_mco;
  logic         r_rco;
  logic         r_ovf;
  logic         r_zero;

  logic         w_last;
  logic         w_zacc_nx;
  logic [W-1:0] w_work_nx;

  assign w_last    = (r_pass == LAST);
  assign w_zacc_nx = r_zacc & (alu_out == 4'd0);

  // Working register with the current pass's nibble merged in.
  always_comb begin
    w_work_nx = r_work;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == 3'(i)) w_work_nx[4*i +: 4] = alu_out;
    end
  end

  // State register plus registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
      r_done  <= (w_state_nx == DONE);
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nx = RUN;
      RUN:     if (w_last) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // ALU drive, decoded from registered state only.
  always_comb begin
    alu_op  = 4'd0;
    alu_a   = 4'd0;
    alu_b   = 4'd0;
    alu_mci = 1'b0;
    alu_rci = 1'b0;
    if (r_state == RUN) begin
      alu_op  = (r_pass == 3'd0) ? r_op_first : r_op_chain;
      alu_a   = nib_sel(32'(r_a), r_idx);
      alu_b   = nib_sel(32'(r_b), r_idx);
      alu_mci = r_mc;
      alu_rci = r_rc;
    end
  end

  // Command capture, per-pass datapath and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_first <= '0;
      r_op_chain <= '0;
      r_msb      <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_mc       <= 1'b0;
      r_rc       <= 1'b0;
      r_zacc     <= 1'b0;
      r_idx      <= '0;
      r_pass     <= '0;
      r_work     <= '0;
      r_result   <= '0;
      r_mco      <= 1'b0;
      r_rco      <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_op_first <= cmd_op_first;
            r_op_chain <= cmd_op_chain;
            r_msb      <= cmd_msb_first;
            r_a        <= cmd_a;
            r_b        <= cmd_b;
            r_mc       <= cmd_mci;
            r_rc       <= cmd_rci;
            r_zacc     <= 1'b1;
            r_idx      <= cmd_msb_first ? LAST : 3'd0;
            r_pass     <= '0;
            r_work     <= '0;
          end
        end
        RUN: begin
          r_work <= w_work_nx;
          r_mc   <= alu_mco;
          r_rc   <= alu_rco;
          r_zacc <= w_zacc_nx;
          r_idx  <= r_msb ? r_idx - 3'd1 : r_idx + 3'd1;
          r_pass <= r_pass + 3'd1;
          if (w_last) begin
            r_result <= w_work_nx;
            r_mco    <= alu_mco;
            r_rco    <= alu_rco;
            r_ovf    <= alu_ovf;
            r_zero   <= w_zacc_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign mco    = r_mco;
  assign rco    = r_rco;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule
